// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch slice.
// Latency: n/a (package). Backpressure: n/a.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [5:0] OPCODE_J   = 6'b000010;
    localparam logic [5:0] OPCODE_BEQ = 6'b000100;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM26_MSB  = 25;
    localparam int IMM26_LSB  = 0;

    // Pseudo-direct jump: keep the region nibble of pc+4, splice in the word index.
    function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                                input logic [25:0] imm26);
        return {region, imm26, 2'b00};
    endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Next-PC select: jump beats branch, branch beats fall-through; all sums wrap mod 2^32.
// Latency: combinational. Backpressure: none.
module mips_next_pc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] imm26,
    input  logic        jump,
    input  logic        pc_src,
    input  logic [31:0] sign_imm,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target(pc_plus4[31:28], imm26);
        end else if (pc_src) begin
            next_pc = pc_plus4 + (sign_imm << 2);
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word per instruction, holds it until retire (FETCH_TIMEOUT_EN adds a WAIT watchdog).
// Latency: IDLE one cycle after reset, then REQ -> WAIT (>=1 cycle) -> HOLD; instr_valid rises the cycle after imem_rvalid.
// Backpressure: HOLD stalls indefinitely until retire; imem_rvalid outside WAIT and retire outside HOLD are dropped.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        retire,
    input  logic        pc_src,
    input  logic        jump,
    input  logic [31:0] sign_imm,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    if ((RESET_PC[1:0] != 2'b00) || (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 31)) begin : g_param_check
        $fatal(1, "mips_fetch_unit: RESET_PC must be word-aligned and TIMEOUT_CYCLES in 1..31");
    end

    fetch_state_t state, state_nxt;
    logic         capture;
    logic         advance;
    logic         timeout;
    logic [31:0]  next_pc;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];
    assign funct     = instr[FUNCT_MSB:FUNCT_LSB];

    mips_next_pc u_next_pc (
        .pc_plus4 (pc_plus4),
        .imm26    (instr[IMM26_MSB:IMM26_LSB]),
        .jump     (jump),
        .pc_src   (pc_src),
        .sign_imm (sign_imm),
        .next_pc  (next_pc)
    );

`ifdef FETCH_TIMEOUT_EN
    logic [4:0] wait_cnt;
    logic       err_q;

    assign timeout   = (state == WAIT) && (wait_cnt == 5'(TIMEOUT_CYCLES - 1));
    assign fetch_err = err_q;

    // Counter is held at zero outside WAIT so every WAIT entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 5'd0;
            err_q    <= 1'b0;
        end else begin
            if (state != WAIT) begin
                wait_cnt <= 5'd0;
            end else begin
                wait_cnt <= wait_cnt + 5'd1;
            end
            if (timeout && !imem_rvalid) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        advance     = 1'b0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                imem_req  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A response arriving on the timeout cycle still wins.
                if (imem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end else if (timeout) begin
                    state_nxt = REQ;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (retire) begin
                    advance   = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            instr <= 32'd0;
        end else begin
            if (capture) begin
                instr <= imem_rdata;
            end
            if (advance) begin
                pc <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomized bench for mips_fetch_unit: a memory responder with variable latency and a
// PC reference model built from the next-PC rules; all drives and samples on the falling edge.
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        instr_valid;
    logic        retire;
    logic        pc_src;
    logic        jump;
    logic [31:0] sign_imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_pc;

    always #5 clk = ~clk;

    mips_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .funct       (funct),
        .instr_valid (instr_valid),
        .retire      (retire),
        .pc_src      (pc_src),
        .jump        (jump),
        .sign_imm    (sign_imm),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_err   (fetch_err)
    );

    task automatic clear_inputs();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        retire      = 1'b0;
        pc_src      = 1'b0;
        jump        = 1'b0;
        sign_imm    = 32'd0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL req_wait: imem_req=%b required 1 within 60 cycles", imem_req);
        end
    endtask

    // One full instruction: request, memory response after lat cycles, hold, retire.
    task automatic do_fetch(input int lat, input logic [31:0] word, input logic j,
                            input logic ps, input logic [31:0] simm, input bit spur,
                            input int hold);
        logic [31:0] pc4;
        logic [31:0] exp_next;
        wait_req();
        n_checks++;
        if (imem_addr !== model_pc) begin
            n_fail++;
            $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, model_pc);
        end
        if (spur) begin
            retire      = 1'b1;
            jump        = 1'b1;
            pc_src      = 1'b1;
            sign_imm    = $urandom;
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) clear_inputs();
            n_checks++;
            if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_state: instr_valid=%b imem_req=%b required 0/0", instr_valid, imem_req);
            end
            imem_rvalid = (k == lat);
            imem_rdata  = (k == lat) ? word : $urandom;
        end
        @(negedge clk);
        imem_rvalid = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== word) begin
            n_fail++;
            $display("FAIL capture: instr_valid=%b instr=%h required 1 %h", instr_valid, instr, word);
        end
        n_checks++;
        if (opcode !== 6'(word >> 26) || funct !== 6'(word & 32'h3F)) begin
            n_fail++;
            $display("FAIL fields: opcode=%h funct=%h required %h %h", opcode, funct,
                     6'(word >> 26), 6'(word & 32'h3F));
        end
        n_checks++;
        if (pc !== model_pc || pc_plus4 !== model_pc + 32'd4) begin
            n_fail++;
            $display("FAIL pc_hold: pc=%h pc_plus4=%h required %h %h", pc, pc_plus4, model_pc, model_pc + 32'd4);
        end
        for (int h = 0; h < hold; h++) begin
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            @(negedge clk);
            n_checks++;
            if (instr_valid !== 1'b1 || instr !== word) begin
                n_fail++;
                $display("FAIL hold_stable: instr_valid=%b instr=%h required 1 %h", instr_valid, instr, word);
            end
        end
        imem_rvalid = 1'b0;
        retire      = 1'b1;
        jump        = j;
        pc_src      = ps;
        sign_imm    = simm;
        pc4 = model_pc + 32'd4;
        if (j)       exp_next = (pc4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
        else if (ps) exp_next = pc4 + simm * 4;
        else         exp_next = pc4;
        @(negedge clk);
        clear_inputs();
        n_checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || pc !== exp_next) begin
            n_fail++;
            $display("FAIL retire: instr_valid=%b imem_req=%b pc=%h required 0 1 %h",
                     instr_valid, imem_req, pc, exp_next);
        end
        model_pc = exp_next;
    endtask

    // Reach an arbitrary aligned pc through a branch with a computed offset.
    task automatic steer(input logic [31:0] target);
        logic [31:0] simm;
        simm = (target - (model_pc + 32'd4)) >> 2;
        do_fetch(1, $urandom, 1'b0, 1'b1, simm, 1'b0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        n_checks++;
        if (pc !== 32'd0 || instr !== 32'd0 || opcode !== 6'd0 || funct !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_regs: pc=%h instr=%h opcode=%h funct=%h required all 0", pc, instr, opcode, funct);
        end
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: req=%b valid=%b err=%b required 0 0 0", imem_req, instr_valid, fetch_err);
        end
        // Spurious rvalid/retire during the IDLE cycle must be ignored.
        rst_n       = 1'b1;
        retire      = 1'b1;
        jump        = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        clear_inputs();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0 || instr !== 32'd0 || pc !== 32'd0) begin
            n_fail++;
            $display("FAIL first_req: req=%b addr=%h instr=%h pc=%h required 1 0 0 0", imem_req, imem_addr, instr, pc);
        end
        model_pc = 32'd0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) do_fetch(1, $urandom, 1'b0, 1'b0, $urandom, 1'b0, 1);
        n_checks++;
        if (pc !== 32'h0000_000C) begin
            n_fail++;
            $display("FAIL sequential: pc=%h required 0000000c", pc);
        end
    endtask

    task automatic test_branch();
        steer(32'h0000_0100);
        do_fetch(1, $urandom, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 0);
        wait_req();
        n_checks++;
        if (imem_addr !== 32'h0000_00FC) begin
            n_fail++;
            $display("FAIL branch_back: imem_addr=%h required 000000fc", imem_addr);
        end
    endtask

    task automatic test_jump();
        steer(32'h1000_0000);
        do_fetch(2, 32'h0800_0040, 1'b1, 1'b0, $urandom, 1'b0, 0);
        n_checks++;
        if (pc !== 32'h1000_0100) begin
            n_fail++;
            $display("FAIL jump: pc=%h required 10000100", pc);
        end
        steer(32'h1000_0000);
        do_fetch(1, 32'h0800_0040, 1'b1, 1'b1, $urandom, 1'b0, 1);
        n_checks++;
        if (pc !== 32'h1000_0100) begin
            n_fail++;
            $display("FAIL jump_over_branch: pc=%h required 10000100", pc);
        end
    endtask

    task automatic test_wrap();
        steer(32'hFFFF_FFFC);
        do_fetch(1, $urandom, 1'b0, 1'b0, $urandom, 1'b0, 0);
        n_checks++;
        if (pc !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap: pc=%h required 00000000", pc);
        end
    endtask

    task automatic test_latency();
        do_fetch(5, $urandom, 1'b0, 1'b0, $urandom, 1'b1, 2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            do_fetch($urandom_range(1, 6), $urandom, 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 2) == 0), $urandom, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_wait();
        wait_req();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pc !== 32'd0 || instr !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait_reset: pc=%h instr=%h valid=%b req=%b required 0 0 0 0",
                     pc, instr, instr_valid, imem_req);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        clear_inputs();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0 || instr !== 32'd0) begin
            n_fail++;
            $display("FAIL stale_rvalid: req=%b addr=%h instr=%h required 1 0 0", imem_req, imem_addr, instr);
        end
        model_pc = 32'd0;
        do_fetch(1, $urandom, 1'b0, 1'b0, $urandom, 1'b0, 0);
    endtask

    task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
        int n = 0;
        wait_req();
        do begin
            @(negedge clk);
            n++;
        end while (imem_req !== 1'b1 && n < 40);
        n_checks++;
        if (n !== 17 || imem_addr !== model_pc || fetch_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_reissue: cycles=%0d addr=%h err=%b required 17 %h 1", n, imem_addr, model_pc, fetch_err);
        end
        do_fetch(2, $urandom, 1'b0, 1'b0, $urandom, 1'b0, 0);
        n_checks++;
        if (fetch_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: fetch_err=%b required 1", fetch_err);
        end
`else
        do_fetch(24, $urandom, 1'b0, 1'b0, $urandom, 1'b0, 0);
        n_checks++;
        if (fetch_err !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout: fetch_err=%b required 0", fetch_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_wrap();
        test_latency();
        test_random();
        test_reset_mid_wait();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
